// File: rtl/conv_mac_tree_acc_pkg.sv
// Purpose: shared defaults and elaboration-time helpers for the SIMD MAC tree accumulator.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package conv_mac_tree_acc_pkg;

    localparam int DEF_KERNEL_NUM  = 9;
    localparam int DEF_PICTURE_NUM = 8;
    localparam int DEF_WIDTH_DATA  = 8;
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_MULT_LAT    = 2;

    // Ceiling log2; returns 0 for n <= 1, so a single-tap tree has no adder levels.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of nodes present at a given tree level (level 0 = products).
    function automatic int tree_nodes(input int taps, input int level);
        int n;
        n = taps;
        for (int l = 0; l < level; l++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/conv_mac_tree_acc_simd_mult_reg.sv
// Purpose: PICTURE_NUM signed multipliers sharing one weight, followed by MULT_LAT registers.
// Latency: MULT_LAT cycles. Backpressure: none, a new operand set is taken every cycle.
// Ports: clk; data_in (lane p at p*WIDTH_DATA); weight_in; prod_out (lane p at p*2*WIDTH_DATA, signed).
module conv_mac_tree_acc_simd_mult_reg
    import conv_mac_tree_acc_pkg::*;
#(
    parameter int PICTURE_NUM = DEF_PICTURE_NUM,
    parameter int WIDTH_DATA  = DEF_WIDTH_DATA,
    parameter int MULT_LAT    = DEF_MULT_LAT
) (
    input  logic                                clk,
    input  logic [PICTURE_NUM*WIDTH_DATA-1:0]   data_in,
    input  logic [WIDTH_DATA-1:0]               weight_in,
    output logic [PICTURE_NUM*2*WIDTH_DATA-1:0] prod_out
);

    localparam int PW = 2 * WIDTH_DATA;

    logic [PICTURE_NUM*PW-1:0] prod_c;
    logic [PICTURE_NUM*PW-1:0] stage [MULT_LAT];

    // Operands are widened before the multiply so the full product width is kept.
    always_comb begin
        prod_c = '0;
        for (int p = 0; p < PICTURE_NUM; p++) begin
            prod_c[p*PW +: PW] = PW'($signed(data_in[p*WIDTH_DATA +: WIDTH_DATA]))
                               * PW'($signed(weight_in));
        end
    end

    // Datapath registers carry no reset; validity is tracked by the sideband in the top.
    always_ff @(posedge clk) begin
        stage[0] <= prod_c;
        for (int k = 1; k < MULT_LAT; k++) begin
            stage[k] <= stage[k-1];
        end
    end

    assign prod_out = stage[MULT_LAT-1];

endmodule

// File: rtl/conv_mac_tree_acc.sv
// Purpose: SIMD convolution MAC: per-tap multiply, registered adder tree, channel accumulation.
// Latency: MULT_LAT + clog2(KERNEL_NUM) + 2 cycles from a last beat to out_valid.
// Backpressure: none; every in_valid beat is accepted. Ports: clk/rst, in_* beat + framing,
// data_in (tap i lane p at (i*PICTURE_NUM+p)*WIDTH_DATA), weight_in, out_valid/data_out, busy.
module conv_mac_tree_acc
    import conv_mac_tree_acc_pkg::*;
#(
    parameter int KERNEL_NUM  = DEF_KERNEL_NUM,
    parameter int PICTURE_NUM = DEF_PICTURE_NUM,
    parameter int WIDTH_DATA  = DEF_WIDTH_DATA,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int MULT_LAT    = DEF_MULT_LAT
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    input  logic                                         in_first,
    input  logic                                         in_last,
    input  logic [PICTURE_NUM*KERNEL_NUM*WIDTH_DATA-1:0] data_in,
    input  logic [KERNEL_NUM*WIDTH_DATA-1:0]             weight_in,
    output logic                                         out_valid,
    output logic [PICTURE_NUM*ACC_WIDTH-1:0]             data_out,
    output logic                                         busy
);

    localparam int D      = clog2(KERNEL_NUM);
    localparam int PW     = 2 * WIDTH_DATA;
    localparam int SW     = PW + D;
    localparam int SB_LEN = MULT_LAT + D;
    localparam int LANE_W = PICTURE_NUM * WIDTH_DATA;

    logic [KERNEL_NUM*PICTURE_NUM*PW-1:0] prod;
    logic [PICTURE_NUM*SW-1:0]            tree_sum;

    genvar gi, gl, gn;

    for (gi = 0; gi < KERNEL_NUM; gi++) begin : g_tap
        conv_mac_tree_acc_simd_mult_reg #(
            .PICTURE_NUM (PICTURE_NUM),
            .WIDTH_DATA  (WIDTH_DATA),
            .MULT_LAT    (MULT_LAT)
        ) u_simd_mult_reg (
            .clk       (clk),
            .data_in   (data_in[gi*LANE_W +: LANE_W]),
            .weight_in (weight_in[gi*WIDTH_DATA +: WIDTH_DATA]),
            .prod_out  (prod[gi*PICTURE_NUM*PW +: PICTURE_NUM*PW])
        );
    end

    // Level gl holds tree_nodes(gl) nodes of width PW+gl; node n lane p at (n*PICTURE_NUM+p)*LW.
    for (gl = 0; gl <= D; gl++) begin : g_lvl
        localparam int N  = tree_nodes(KERNEL_NUM, gl);
        localparam int LW = PW + gl;
        logic [N*PICTURE_NUM*LW-1:0] node;

        if (gl == 0) begin : g_leaf
            assign node = prod;
        end else begin : g_sum
            localparam int NP = tree_nodes(KERNEL_NUM, gl - 1);
            localparam int LP = LW - 1;
            for (gn = 0; gn < N; gn++) begin : g_node
                logic [PICTURE_NUM*LW-1:0] q;
                if (2*gn + 1 < NP) begin : g_pair
                    always_ff @(posedge clk) begin
                        for (int p = 0; p < PICTURE_NUM; p++) begin
                            q[p*LW +: LW] <=
                                LW'($signed(g_lvl[gl-1].node[((2*gn)*PICTURE_NUM+p)*LP +: LP]))
                              + LW'($signed(g_lvl[gl-1].node[((2*gn+1)*PICTURE_NUM+p)*LP +: LP]));
                        end
                    end
                end else begin : g_pass
                    // Odd leftover: registered without an add to keep every path equally deep.
                    always_ff @(posedge clk) begin
                        for (int p = 0; p < PICTURE_NUM; p++) begin
                            q[p*LW +: LW] <=
                                LW'($signed(g_lvl[gl-1].node[((2*gn)*PICTURE_NUM+p)*LP +: LP]));
                        end
                    end
                end
                assign node[gn*PICTURE_NUM*LW +: PICTURE_NUM*LW] = q;
            end
        end
    end

    assign tree_sum = g_lvl[D].node;

    // Sideband shift register, one stage per datapath register ahead of the accumulator.
    logic [SB_LEN-1:0] sb_vld, sb_first, sb_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_vld   <= '0;
            sb_first <= '0;
            sb_last  <= '0;
        end else begin
            sb_vld[0]   <= in_valid;
            sb_first[0] <= in_valid & in_first;
            sb_last[0]  <= in_valid & in_last;
            for (int k = 1; k < SB_LEN; k++) begin
                sb_vld[k]   <= sb_vld[k-1];
                sb_first[k] <= sb_first[k-1];
                sb_last[k]  <= sb_last[k-1];
            end
        end
    end

    logic                             acc_vld, acc_last;
    logic [PICTURE_NUM*ACC_WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_vld  <= 1'b0;
            acc_last <= 1'b0;
            acc      <= '0;
        end else begin
            acc_vld  <= sb_vld[SB_LEN-1];
            acc_last <= sb_vld[SB_LEN-1] & sb_last[SB_LEN-1];
            if (sb_vld[SB_LEN-1]) begin
                for (int p = 0; p < PICTURE_NUM; p++) begin
                    if (sb_first[SB_LEN-1]) begin
                        acc[p*ACC_WIDTH +: ACC_WIDTH] <= ACC_WIDTH'($signed(tree_sum[p*SW +: SW]));
                    end else begin
                        // Wraps in two's complement; a last without a first keeps adding.
                        acc[p*ACC_WIDTH +: ACC_WIDTH] <= acc[p*ACC_WIDTH +: ACC_WIDTH]
                            + ACC_WIDTH'($signed(tree_sum[p*SW +: SW]));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= acc_last;
            if (acc_last) begin
                data_out <= acc;
            end
        end
    end

    assign busy = (|sb_vld) | acc_vld;

endmodule
